// File: rtl/shared_sqscmul_gf4_pipe_if.sv
// Handshake and share bus for the masked GF(4) square-scale-multiply unit.
// Share packing: lane L, share i, bit j at (L*SHARES+i)*4+j; randomness: lane L, nibble r at (L*RPL+r)*4.
interface shared_sqscmul_gf4_pipe_if #(
  parameter int SHARES = 4,
  parameter int LANES  = 1
);
  localparam int RPL = SHARES * (SHARES - 1) / 2;

  logic                        InValidxSI;
  logic                        InReadyxSO;
  logic                        ModexSI;
  logic [LANES*SHARES*4-1:0]   _XxDI;
  logic [LANES*SHARES*4-1:0]   _YxDI;
  logic [LANES*RPL*4-1:0]      _ZxDI;
  logic                        OutValidxSO;
  logic                        OutReadyxSI;
  logic [LANES*SHARES*4-1:0]   _QxDO;

  modport master (
    output InValidxSI, ModexSI, _XxDI, _YxDI, _ZxDI, OutReadyxSI,
    input  InReadyxSO, OutValidxSO, _QxDO
  );

  modport slave (
    input  InValidxSI, ModexSI, _XxDI, _YxDI, _ZxDI, OutReadyxSI,
    output InReadyxSO, OutValidxSO, _QxDO
  );
endinterface

// File: rtl/shared_sqscmul_gf4_pipe.sv
// DOM-indep masked square-scale-multiply, Q = X*Y ^ sqsc(X^Y) (or X*Y), with valid/ready and 1-2 stages.
// Optional macro SHARED_SQSCMUL_IDLE_HOLD_EN: data registers load only on real transactions.
module shared_sqscmul_gf4_pipe #(
  parameter  int SHARES     = 4,
  parameter  int LANES      = 1,
  parameter  int PIPE_DEPTH = 1,
  localparam int RPL        = SHARES * (SHARES - 1) / 2
) (
  input logic                    ClkxCI,
  input logic                    RstxBI,
  shared_sqscmul_gf4_pipe_if.slave io
);

  localparam int QW = LANES * SHARES * 4;

  // Normal-basis GF(2^2) product.
  function automatic logic [1:0] gf4Mul(input logic [1:0] a, input logic [1:0] b);
    logic m;
    m = (a[1] ^ a[0]) & (b[1] ^ b[0]);
    return {(a[1] & b[1]) ^ m, (a[0] & b[0]) ^ m};
  endfunction

  function automatic logic [1:0] gf4SclN(input logic [1:0] a);
    return {a[0], a[1] ^ a[0]};
  endfunction

  // Tower-field nibble product (gf2_mul, N=4).
  function automatic logic [3:0] gf2Mul(input logic [3:0] a, input logic [3:0] b);
    logic [1:0] ph, pl, p;
    ph = gf4Mul(a[3:2], b[3:2]);
    pl = gf4Mul(a[1:0], b[1:0]);
    p  = gf4SclN(gf4Mul(a[3:2] ^ a[1:0], b[3:2] ^ b[1:0]));
    return {ph ^ p, pl ^ p};
  endfunction

  // Linear square-and-scale map used in the inversion.
  function automatic logic [3:0] squareScaler(input logic [3:0] d);
    return {d[2] ^ d[0], d[3] ^ d[1], d[1] ^ d[0], d[0]};
  endfunction

  logic       stall, accept, ldFF;
  logic       vld_p1;
  logic [3:0] ffxDN    [LANES][SHARES][SHARES];
  logic [3:0] ffxDP_p1 [LANES][SHARES][SHARES];
  logic [QW-1:0] qSumxD;

  assign stall         = io.OutValidxSO & ~io.OutReadyxSI;
  assign io.InReadyxSO = ~stall;
  assign accept        = io.InValidxSI & ~stall;

`ifdef SHARED_SQSCMUL_IDLE_HOLD_EN
  assign ldFF = accept;
`else
  assign ldFF = ~stall;
`endif

  // Cross-domain terms; every off-diagonal pair (k,l)/(l,k) shares one fresh nibble.
  always_comb begin
    for (int ln = 0; ln < LANES; ln++) begin
      for (int k = 0; k < SHARES; k++) begin
        for (int l = 0; l < SHARES; l++) begin
          if (k == l)
            ffxDN[ln][k][l] = gf2Mul(io._XxDI[(ln*SHARES+k)*4 +: 4], io._YxDI[(ln*SHARES+l)*4 +: 4])
                            ^ (io.ModexSI ? squareScaler(io._XxDI[(ln*SHARES+k)*4 +: 4]
                                                         ^ io._YxDI[(ln*SHARES+k)*4 +: 4]) : 4'h0);
          else if (l > k)
            ffxDN[ln][k][l] = gf2Mul(io._XxDI[(ln*SHARES+k)*4 +: 4], io._YxDI[(ln*SHARES+l)*4 +: 4])
                            ^ io._ZxDI[(ln*RPL + k + l*(l-1)/2)*4 +: 4];
          else
            ffxDN[ln][k][l] = gf2Mul(io._XxDI[(ln*SHARES+k)*4 +: 4], io._YxDI[(ln*SHARES+l)*4 +: 4])
                            ^ io._ZxDI[(ln*RPL + l + k*(k-1)/2)*4 +: 4];
        end
      end
    end
  end

  // ---- stage 1: cross-domain register ----
  always_ff @(posedge ClkxCI or negedge RstxBI) begin
    if (!RstxBI) begin
      ffxDP_p1 <= '{default: '0};
      vld_p1   <= 1'b0;
    end else begin
      if (!stall) vld_p1 <= accept;
      if (ldFF)   ffxDP_p1 <= ffxDN;
    end
  end

  // Compression only ever sees registered cross-domain terms.
  always_comb begin
    qSumxD = '0;
    for (int ln = 0; ln < LANES; ln++)
      for (int k = 0; k < SHARES; k++)
        for (int l = 0; l < SHARES; l++)
          qSumxD[(ln*SHARES+k)*4 +: 4] = qSumxD[(ln*SHARES+k)*4 +: 4] ^ ffxDP_p1[ln][k][l];
  end

  generate
    if (PIPE_DEPTH == 2) begin : g_stage2
      logic          vld_p2;
      logic          ld2;
      logic [QW-1:0] qxDP_p2;

`ifdef SHARED_SQSCMUL_IDLE_HOLD_EN
      assign ld2 = vld_p1 & ~stall;
`else
      assign ld2 = ~stall;
`endif

      // ---- stage 2: compressed share register ----
      always_ff @(posedge ClkxCI or negedge RstxBI) begin
        if (!RstxBI) begin
          qxDP_p2 <= '0;
          vld_p2  <= 1'b0;
        end else begin
          if (!stall) vld_p2 <= vld_p1;
          if (ld2)    qxDP_p2 <= qSumxD;
        end
      end

      assign io.OutValidxSO = vld_p2;
      assign io._QxDO       = qxDP_p2;
    end else begin : g_stage1
      assign io.OutValidxSO = vld_p1;
      assign io._QxDO       = qSumxD;
    end
  endgenerate

endmodule

// File: tb/tb_shared_sqscmul_gf4_pipe.sv
// Directed bench: single-lane 1-stage unit and dual-lane 2-stage unit, checked against a log-table GF model.
module tb_shared_sqscmul_gf4_pipe;

  logic ClkxCI = 1'b0;
  logic RstxBI = 1'b0;
  always #5 ClkxCI = ~ClkxCI;

  shared_sqscmul_gf4_pipe_if #(.SHARES(4), .LANES(1)) if1 ();
  shared_sqscmul_gf4_pipe_if #(.SHARES(4), .LANES(2)) if2 ();

  shared_sqscmul_gf4_pipe #(.SHARES(4), .LANES(1), .PIPE_DEPTH(1)) dut1 (
    .ClkxCI(ClkxCI), .RstxBI(RstxBI), .io(if1.slave));
  shared_sqscmul_gf4_pipe #(.SHARES(4), .LANES(2), .PIPE_DEPTH(2)) dut2 (
    .ClkxCI(ClkxCI), .RstxBI(RstxBI), .io(if2.slave));

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // GF(4) via discrete log: 11 = 1, 10 = w, 01 = w^2.
  function automatic int lg(input logic [1:0] a);
    case (a)
      2'b11:   return 0;
      2'b10:   return 1;
      default: return 2;
    endcase
  endfunction

  function automatic logic [1:0] m4(input logic [1:0] a, input logic [1:0] b);
    int e;
    if (a == 2'b00 || b == 2'b00) return 2'b00;
    e = (lg(a) + lg(b)) % 3;
    case (e)
      0:       return 2'b11;
      1:       return 2'b10;
      default: return 2'b01;
    endcase
  endfunction

  function automatic logic [3:0] gfRef(input logic [3:0] a, input logic [3:0] b);
    logic [1:0] s;
    s = m4(m4(a[3:2] ^ a[1:0], b[3:2] ^ b[1:0]), 2'b10);
    return {m4(a[3:2], b[3:2]) ^ s, m4(a[1:0], b[1:0]) ^ s};
  endfunction

  function automatic logic [3:0] sqscRef(input logic [3:0] a);
    logic [1:0] s;
    s = a[3:2] ^ a[1:0];
    return {m4(s, s), m4(m4(a[1:0], a[1:0]), 2'b01)};
  endfunction

  function automatic logic [15:0] share4(input logic [3:0] v);
    logic [15:0] s;
    s = 16'($urandom);
    s[15:12] = v ^ s[3:0] ^ s[7:4] ^ s[11:8];
    return s;
  endfunction

  function automatic logic [3:0] uns4(input logic [15:0] s);
    return s[3:0] ^ s[7:4] ^ s[11:8] ^ s[15:12];
  endfunction

  function automatic logic [7:0] uns2(input logic [31:0] s);
    return {uns4(s[31:16]), uns4(s[15:0])};
  endfunction

  task automatic send1(input logic [15:0] xsh, input logic [15:0] ysh, input logic md);
    @(negedge ClkxCI);
    if1.InValidxSI = 1'b1;
    if1.ModexSI    = md;
    if1._XxDI      = xsh;
    if1._YxDI      = ysh;
    if1._ZxDI      = 24'($urandom);
    @(posedge ClkxCI); #1;
    if1.InValidxSI = 1'b0;
  endtask

  logic [7:0]  tX [4];
  logic [7:0]  tY [4];
  logic        tM [4];
  logic [31:0] sX [4];
  logic [31:0] sY [4];

  function automatic logic [7:0] exp2(input int i);
    logic [7:0] r;
    for (int ln = 0; ln < 2; ln++)
      r[ln*4 +: 4] = gfRef(tX[i][ln*4 +: 4], tY[i][ln*4 +: 4])
                   ^ (tM[i] ? sqscRef(tX[i][ln*4 +: 4] ^ tY[i][ln*4 +: 4]) : 4'h0);
    return r;
  endfunction

  task automatic drive2(input int i);
    if2.InValidxSI = 1'b1;
    if2.ModexSI    = tM[i];
    if2._XxDI      = sX[i];
    if2._YxDI      = sY[i];
    if2._ZxDI      = {16'($urandom), 32'($urandom)};
  endtask

  logic [15:0] xs, ys, snap1;
  logic [31:0] snap2;
  logic [3:0]  domSum;

  initial begin
    if1.InValidxSI = 0; if1.ModexSI = 0; if1._XxDI = '0; if1._YxDI = '0; if1._ZxDI = '0;
    if1.OutReadyxSI = 1;
    if2.InValidxSI = 0; if2.ModexSI = 0; if2._XxDI = '0; if2._YxDI = '0; if2._ZxDI = '0;
    if2.OutReadyxSI = 1;
    tX = '{8'h59, 8'h3C, 8'hA7, 8'h1F};
    tY = '{8'h95, 8'hE2, 8'h4B, 8'hF0};
    tM = '{1'b0, 1'b1, 1'b0, 1'b1};

    // Reset state
    repeat (2) @(posedge ClkxCI);
    #1;
    chk("rst_vld1", 32'(if1.OutValidxSO), 32'd0);
    chk("rst_q1",   32'(if1._QxDO),       32'd0);
    chk("rst_rdy1", 32'(if1.InReadyxSO),  32'd1);
    chk("rst_vld2", 32'(if2.OutValidxSO), 32'd0);
    chk("rst_q2",   32'(if2._QxDO),       32'd0);
    @(negedge ClkxCI);
    RstxBI = 1'b1;

    // Test 1: zero operands, 1-cycle latency
    @(negedge ClkxCI);
    if1.InValidxSI = 1'b1; if1.ModexSI = 1'b0;
    if1._XxDI = share4(4'h0); if1._YxDI = share4(4'h0); if1._ZxDI = 24'($urandom);
    #1 chk("t1_vld_before", 32'(if1.OutValidxSO), 32'd0);
    @(posedge ClkxCI); #1;
    if1.InValidxSI = 1'b0;
    chk("t1_vld", 32'(if1.OutValidxSO), 32'd1);
    chk("t1_q",   32'(uns4(if1._QxDO)), 32'd0);
    @(posedge ClkxCI); #1;
    chk("t1_vld_drop", 32'(if1.OutValidxSO), 32'd0);

    // Test 2: plain multiply, hand anchors then all pairs
    send1(share4(4'h5), share4(4'h9), 1'b0);
    chk("t2_vld", 32'(if1.OutValidxSO), 32'd1);
    chk("t2_mul_5_9", 32'(uns4(if1._QxDO)), 32'hE);
    send1(share4(4'hF), share4(4'h7), 1'b0);
    chk("t2_mul_F_7", 32'(uns4(if1._QxDO)), 32'h7);
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        send1(share4(4'(a)), share4(4'(b)), 1'b0);
        chk("t2_mul_all", {16'(a), 8'(b), 4'h0, uns4(if1._QxDO)}, {16'(a), 8'(b), 4'h0, gfRef(4'(a), 4'(b))});
      end
    end

    // Test 3: square-scale mode, identical sharings cancel the domain terms
    xs = share4(4'h5);
    send1(xs, xs, 1'b1);
    chk("t3_sq_5", 32'(uns4(if1._QxDO)), 32'hA);
    for (int a = 0; a < 16; a++) begin
      xs = share4(4'(a));
      send1(xs, xs, 1'b1);
      chk("t3_sq_all", {16'(a), 12'h0, uns4(if1._QxDO)}, {16'(a), 12'h0, gfRef(4'(a), 4'(a))});
    end
    send1(share4(4'h1), share4(4'h0), 1'b1);
    chk("t3_sqsc_1_0", 32'(uns4(if1._QxDO)), 32'hB);
    for (int n = 0; n < 16; n++) begin
      xs = 16'($urandom);
      ys = 16'($urandom);
      domSum = 4'h0;
      for (int i = 0; i < 4; i++) domSum = domSum ^ sqscRef(xs[i*4 +: 4] ^ ys[i*4 +: 4]);
      send1(xs, ys, 1'b1);
      chk("t3_sqsc_gen", 32'(uns4(if1._QxDO)), 32'(gfRef(uns4(xs), uns4(ys)) ^ domSum));
    end

    // Test 6: idle bus with toggling operands
    @(posedge ClkxCI); #1;
    chk("t6_vld_idle0", 32'(if1.OutValidxSO), 32'd0);
    snap1 = if1._QxDO;
    for (int c = 0; c < 10; c++) begin
      @(negedge ClkxCI);
      if (c == 9) begin
        xs = share4(4'h3); ys = share4(4'h6); if1.ModexSI = 1'b0;
      end else begin
        xs = 16'($urandom); ys = 16'($urandom); if1.ModexSI = 1'($urandom);
      end
      if1._XxDI = xs; if1._YxDI = ys; if1._ZxDI = 24'($urandom);
      @(posedge ClkxCI); #1;
      chk("t6_vld_idle", 32'(if1.OutValidxSO), 32'd0);
    end
`ifdef SHARED_SQSCMUL_IDLE_HOLD_EN
    chk("t6_q_hold", 32'(if1._QxDO), 32'(snap1));
`else
    chk("t6_q_load", 32'(uns4(if1._QxDO)), 32'(gfRef(4'h3, 4'h6)));
`endif

    // Test 4: two lanes, two stages, back-pressure
    for (int i = 0; i < 4; i++) begin
      sX[i] = {share4(tX[i][7:4]), share4(tX[i][3:0])};
      sY[i] = {share4(tY[i][7:4]), share4(tY[i][3:0])};
    end
    @(negedge ClkxCI);
    if2.OutReadyxSI = 1'b1;
    drive2(0);
    @(posedge ClkxCI); #1;
    chk("t4_lat_not_yet", 32'(if2.OutValidxSO), 32'd0);
    @(negedge ClkxCI);
    drive2(1);
    @(posedge ClkxCI); #1;
    chk("t4_vld_t0", 32'(if2.OutValidxSO), 32'd1);
    chk("t4_q_t0", 32'(uns2(if2._QxDO)), 32'(exp2(0)));
    @(negedge ClkxCI);
    drive2(2);
    if2.OutReadyxSI = 1'b0;
    #1 chk("t4_rdy_stall", 32'(if2.InReadyxSO), 32'd0);
    snap2 = if2._QxDO;
    for (int c = 0; c < 3; c++) begin
      @(posedge ClkxCI); #1;
      chk("t4_rdy_hold", 32'(if2.InReadyxSO), 32'd0);
      chk("t4_vld_hold", 32'(if2.OutValidxSO), 32'd1);
      chk("t4_q_stable", if2._QxDO, snap2);
    end
    @(negedge ClkxCI);
    if2.OutReadyxSI = 1'b1;
    #1 chk("t4_rdy_release", 32'(if2.InReadyxSO), 32'd1);
    @(posedge ClkxCI); #1;
    chk("t4_vld_t1", 32'(if2.OutValidxSO), 32'd1);
    chk("t4_q_t1", 32'(uns2(if2._QxDO)), 32'(exp2(1)));
    @(negedge ClkxCI);
    drive2(3);
    @(posedge ClkxCI); #1;
    chk("t4_q_t2", 32'(uns2(if2._QxDO)), 32'(exp2(2)));
    @(negedge ClkxCI);
    if2.InValidxSI = 1'b0;
    @(posedge ClkxCI); #1;
    chk("t4_vld_t3", 32'(if2.OutValidxSO), 32'd1);
    chk("t4_q_t3", 32'(uns2(if2._QxDO)), 32'(exp2(3)));
    @(posedge ClkxCI); #1;
    chk("t4_vld_empty", 32'(if2.OutValidxSO), 32'd0);

    // Test 5: async reset while a result is stalled at the output
    @(negedge ClkxCI);
    if2.OutReadyxSI = 1'b0;
    drive2(0);
    repeat (2) @(posedge ClkxCI);
    #1 chk("t5_vld_pre", 32'(if2.OutValidxSO), 32'd1);
    #2 RstxBI = 1'b0;
    #1;
    chk("t5_vld_rst", 32'(if2.OutValidxSO), 32'd0);
    chk("t5_q_rst",   32'(if2._QxDO),       32'd0);
    chk("t5_rdy_rst", 32'(if2.InReadyxSO),  32'd1);
    @(negedge ClkxCI);
    if2.InValidxSI = 1'b0;
    if2.OutReadyxSI = 1'b1;
    RstxBI = 1'b1;
    repeat (2) @(posedge ClkxCI);
    #1 chk("t5_vld_discard", 32'(if2.OutValidxSO), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
